fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, addresses instruction
//  memory and registers the fetched word into the IF/ID pipeline register. Its id_ins output
//  feeds the ID-stage decode controller directly; that controller's jump (jr) decision feeds
//  back as jump_en/jump_target. Supports hazard stall, jump redirect/flush and a fetch counter.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (bits [1:0] must be 0)
//  IMEM_AW   8              instruction-memory word-address width
//  CNT_W     16             width of fetch_count performance counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  stall        in   1        hazard unit: hold PC and IF/ID this cycle
//  jump_en      in   1        ID stage: redirect fetch to jump_target
//  jump_target  in   32       byte address of redirect target
//  imem_addr    out  IMEM_AW  word address to instruction memory, = pc[IMEM_AW+1:2]
//  imem_rdata   in   32       instruction word, combinational read of imem_addr
//  pc           out  32       current fetch PC (byte address)
//  id_ins       out  32       IF/ID instruction register
//  id_pc_plus4  out  32       IF/ID PC+4 register (link/branch base for later stages)
//  id_valid     out  1        IF/ID holds a real instruction (0 = bubble)
//  fetch_count  out  CNT_W    count of instructions accepted into IF/ID
// BEHAVIOUR
//  - Single clock, synchronous active-high reset. All state updates on rising edge of clk.
//  - Reset (rst=1, overrides every other input): pc=RESET_PC, id_ins=32'h0, id_pc_plus4=0,
//    id_valid=0, fetch_count=0. First fetch of RESET_PC happens in the first cycle after rst falls.
//  - imem_addr is combinational from pc; fetch latency to IF/ID = 1 cycle.
//  - Per-cycle priority (rst=0): jump_en > stall > advance.
//    * advance: pc<=pc+4; id_ins<=imem_rdata; id_pc_plus4<=pc+4; id_valid<=1; fetch_count++.
//    * stall (jump_en=0): pc, id_ins, id_pc_plus4, id_valid, fetch_count all hold.
//    * jump_en=1: pc<={jump_target[31:2],2'b00} (low bits forced 0); stall ignored;
//      IF/ID handling of the word fetched this cycle per CONFIGURATION.
//  - Bubble encoding: id_ins=32'h0000_0000 (sll $0,$0,0; decodes as R-type, writes $0 only,
//    harmless), id_valid=0. Downstream must qualify side effects with id_valid.
//  - PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
//  - imem_addr uses only pc[IMEM_AW+1:2]; upper PC bits alias (no fault).
//  - fetch_count increments only when id_valid is written 1; wraps at 2^CNT_W-1 -> 0.
//  - No FSM beyond the two register sets; behaviour above is exhaustive.
// CONFIGURATION
//  DELAY_SLOT_EN defined: on jump_en the word fetched this cycle (delay slot) is captured into
//    IF/ID normally (id_valid<=1, fetch_count++), giving MIPS branch-delay-slot semantics.
//  DELAY_SLOT_EN undefined (default): on jump_en IF/ID is flushed: id_ins<=0, id_pc_plus4<=0,
//    id_valid<=0, fetch_count holds.
// TESTING
//  1 Reset: hold rst 2 cycles, imem returns 32'h2008_0005 -> pc=0, id_valid=0, id_ins=0;
//    cycle after release id_ins=32'h2008_0005, id_pc_plus4=4, pc=4, fetch_count=1.
//  2 Straight line: 4 cycles no stall/jump -> pc 0,4,8,12,16; fetch_count 4; id_valid stays 1.
//  3 Stall: assert stall 3 cycles at pc=8 -> pc, id_ins, fetch_count frozen; resume at pc=12.
//  4 Jump: jump_en=1, jump_target=32'h0000_0042 at pc=16 -> next pc=32'h40; default build:
//    id_valid=0, id_ins=0; DELAY_SLOT_EN build: id_ins=word@16, id_valid=1.
//  5 Jump+stall same cycle -> identical to case 4 (stall ignored).
//  6 Wrap and mid-run reset: jump to 32'hFFFF_FFFC then advance -> pc=0; assert rst while
//    stall=1 and jump_en=1 -> all outputs at reset values next cycle, fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem addressing and the IF/ID pipeline register.
// Optional build macro DELAY_SLOT_EN keeps the word fetched alongside a jump (branch delay slot).
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 8,
   parameter int          CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               jump_en,
   input  logic [31:0]        jump_target,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        pc,
   output logic [31:0]        id_ins,
   output logic [31:0]        id_pc_plus4,
   output logic               id_valid,
   output logic [CNT_W-1:0]   fetch_count
);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ins_q, ins_d;
   logic [31:0]      pc4_q, pc4_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d    = pc_q;
      ins_d   = ins_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (jump_en) begin
         // A jump wins over stall; the redirect target is always word aligned.
         pc_d = {jump_target[31:2], 2'b00};
`ifdef DELAY_SLOT_EN
         ins_d   = imem_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         cnt_d   = cnt_q + CNT_W'(1);
`else
         ins_d   = 32'h0000_0000;
         pc4_d   = 32'h0000_0000;
         valid_d = 1'b0;
`endif
      end else if (!stall) begin
         pc_d    = pc_plus4;
         ins_d   = imem_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ins_q   <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Upper PC bits simply alias onto the smaller instruction memory.
   assign imem_addr   = pc_q[IMEM_AW+1:2];
   assign pc          = pc_q;
   assign id_ins      = ins_q;
   assign id_pc_plus4 = pc4_q;
   assign id_valid    = valid_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a per-cycle reference model.
module tb_fetch_stage;

   localparam int IMEM_AW = 8;
   localparam int CNT_W   = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               stall = 1'b0;
   logic               jump_en = 1'b0;
   logic [31:0]        jump_target = 32'h0;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic [31:0]        pc;
   logic [31:0]        id_ins;
   logic [31:0]        id_pc_plus4;
   logic               id_valid;
   logic [CNT_W-1:0]   fetch_count;

   logic [31:0] mem [256];
   assign imem_rdata = mem[imem_addr];

   fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .id_ins(id_ins),
      .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference state, kept as plain integers
   longint unsigned m_pc, m_ins, m_pc4, m_cnt;
   bit              m_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit s, input bit j, input logic [31:0] jt, input string tag);
      longint unsigned word;
      @(negedge clk);
      rst = r; stall = s; jump_en = j; jump_target = jt;
      word = mem[(m_pc / 4) % 256];
      if (r) begin
         m_pc = 0; m_ins = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
      end else if (j) begin
`ifdef DELAY_SLOT_EN
         m_ins = word; m_pc4 = (m_pc + 4) % 64'h1_0000_0000; m_valid = 1;
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
`else
         m_ins = 0; m_pc4 = 0; m_valid = 0;
`endif
         m_pc = (jt / 4) * 4;
      end else if (!s) begin
         m_ins = word; m_pc = (m_pc + 4) % 64'h1_0000_0000; m_pc4 = m_pc; m_valid = 1;
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      @(posedge clk);
      #1;
      chk({tag, ".pc"},    pc,          32'(m_pc));
      chk({tag, ".ins"},   id_ins,      32'(m_ins));
      chk({tag, ".pc4"},   id_pc_plus4, 32'(m_pc4));
      chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, m_valid});
      chk({tag, ".cnt"},   {28'h0, fetch_count}, 32'(m_cnt));
      chk({tag, ".iaddr"}, {24'h0, imem_addr}, 32'((m_pc / 4) % 256));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h2008_0005;
      m_pc = 0; m_ins = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;

      // reset held two cycles, then straight-line fetch
      step(1, 0, 0, 32'h0, "rst0");
      step(1, 0, 0, 32'h0, "rst1");
      step(0, 0, 0, 32'h0, "first");
      chk("first.ins_const", id_ins, 32'h2008_0005);
      chk("first.pc4_const", id_pc_plus4, 32'h4);
      step(0, 0, 0, 32'h0, "adv");
      // stall three cycles at pc=8
      step(0, 1, 0, 32'h0, "stall0");
      step(0, 1, 0, 32'h0, "stall1");
      step(0, 1, 0, 32'h0, "stall2");
      chk("stall.pc_const", pc, 32'h8);
      step(0, 0, 0, 32'h0, "resume");
      step(0, 0, 0, 32'h0, "adv16");
      // jump with unaligned target, then jump with stall
      step(0, 0, 1, 32'h0000_0042, "jump");
      chk("jump.pc_const", pc, 32'h40);
      step(0, 1, 1, 32'h0000_0083, "jumpstall");
      // wrap, then mid-run reset while stall and jump are also asserted
      step(0, 0, 1, 32'hFFFF_FFFE, "jwrap");
      step(0, 0, 0, 32'h0, "wrap");
      chk("wrap.pc_const", pc, 32'h0);
      step(1, 1, 1, 32'h1234_5678, "midrst");

      // long straight run to exercise counter wrap
      for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, "cntwrap");

      for (int i = 0; i < 400; i++) begin
         bit r, s, j;
         logic [31:0] jt;
         r  = ($urandom_range(0, 49) == 0);
         s  = ($urandom_range(0, 3) == 0);
         j  = ($urandom_range(0, 7) == 0);
         jt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
         step(r, s, j, jt, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
